// File: rtl/button_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_parser_pkg
// Purpose  : Shared debounce defaults and a counter-width helper for the
//            button parser hierarchy.
// Revision : 1.0 - initial release
// ============================================================================
package button_parser_pkg;

    localparam int c_sample_cnt_max_dflt = 25000;
    localparam int c_pulse_cnt_max_dflt  = 150;

    // $clog2 collapses to 0 for n <= 1; a counter needs at least one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int c_sample_cnt_w_dflt = cnt_width(c_sample_cnt_max_dflt);
    localparam int c_pulse_cnt_w_dflt  = cnt_width(c_pulse_cnt_max_dflt + 1);

endpackage : button_parser_pkg
`default_nettype wire

// File: rtl/debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_if
// Purpose  : Button-level bundle between the synchronizer side (master) and
//            the debouncer (slave). Optional: DEBOUNCER_RELEASE_PULSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface debouncer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] glitchy_signal;
    logic [WIDTH-1:0] debounced_signal;
    logic [WIDTH-1:0] press_pulse;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    logic [WIDTH-1:0] release_pulse;
`endif

    modport master (
        output glitchy_signal,
`ifdef DEBOUNCER_RELEASE_PULSE_EN
        input  release_pulse,
`endif
        input  debounced_signal,
        input  press_pulse
    );

    modport slave (
        input  glitchy_signal,
`ifdef DEBOUNCER_RELEASE_PULSE_EN
        output release_pulse,
`endif
        output debounced_signal,
        output press_pulse
    );

endinterface : debouncer_if
`default_nettype wire

// File: rtl/debouncer_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : edge_detector
// Purpose  : Per-bit rise/fall one-shot decode against a registered copy of
//            the input level.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] signal_in,
    output logic      [WIDTH-1:0] rise_pulse,
    output logic      [WIDTH-1:0] fall_pulse
);

    logic [WIDTH-1:0] r_prev_q;
    logic [WIDTH-1:0] w_prev_d;
    logic [WIDTH-1:0] w_run;

    always_comb begin
        w_prev_d = signal_in;
        // Masking with reset keeps the clearing of prev from looking like a release.
        w_run      = {WIDTH{~rst}};
        rise_pulse = signal_in & ~r_prev_q & w_run;
        fall_pulse = ~signal_in & r_prev_q & w_run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_q <= '0;
        end else begin
            r_prev_q <= w_prev_d;
        end
    end

endmodule : edge_detector
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module   : debouncer
// Purpose  : Per-bit saturating-count debouncer with one-shot press pulse.
//            Optional: DEBOUNCER_RELEASE_PULSE_EN adds release_pulse.
// Revision : 1.0 - initial release
// ============================================================================
module debouncer
    import button_parser_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = c_sample_cnt_max_dflt,
    parameter int PULSE_CNT_MAX  = c_pulse_cnt_max_dflt
) (
    input wire logic   clk,
    input wire logic   rst,
    debouncer_if.slave bus
);

    localparam int c_sample_w = cnt_width(SAMPLE_CNT_MAX);
    localparam int c_sat_w    = cnt_width(PULSE_CNT_MAX + 1);
    localparam logic [c_sample_w-1:0] c_sample_last = c_sample_w'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_sat_w-1:0]    c_pulse_max   = c_sat_w'(PULSE_CNT_MAX);

    logic [c_sample_w-1:0] r_sample_cnt_q;
    logic [c_sample_w-1:0] w_sample_cnt_d;
    logic                  w_sample_tick;
    logic [WIDTH-1:0]      w_level;
    logic [WIDTH-1:0]      w_rise;

    always_comb begin
        w_sample_tick  = (r_sample_cnt_q == c_sample_last);
        w_sample_cnt_d = w_sample_tick ? '0 : r_sample_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt_q <= '0;
        end else begin
            r_sample_cnt_q <= w_sample_cnt_d;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_sat_w-1:0] r_sat_cnt_q;
            logic [c_sat_w-1:0] w_sat_cnt_d;

            // A low input wins over everything: any bounce restarts qualification.
            always_comb begin
                w_sat_cnt_d = r_sat_cnt_q;
                if (!bus.glitchy_signal[i]) begin
                    w_sat_cnt_d = '0;
                end else if (w_sample_tick && (r_sat_cnt_q < c_pulse_max)) begin
                    w_sat_cnt_d = r_sat_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sat_cnt_q <= '0;
                end else begin
                    r_sat_cnt_q <= w_sat_cnt_d;
                end
            end

            assign w_level[i] = (r_sat_cnt_q == c_pulse_max) & ~rst;
        end : g_bit
    endgenerate

    assign bus.debounced_signal = w_level;
    assign bus.press_pulse      = w_rise;

`ifdef DEBOUNCER_RELEASE_PULSE_EN
    edge_detector #(
        .WIDTH      (WIDTH)
    ) u_edge_detector (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (w_level),
        .rise_pulse (w_rise),
        .fall_pulse (bus.release_pulse)
    );
`else
    edge_detector #(
        .WIDTH      (WIDTH)
    ) u_edge_detector (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (w_level),
        .rise_pulse (w_rise),
        .fall_pulse ()
    );
`endif

endmodule : debouncer
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_debouncer
// Purpose  : Directed bench for debouncer (WIDTH=2, SAMPLE=4, PULSE=3).
//            Optional: DEBOUNCER_RELEASE_PULSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debouncer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   press_cnt0;
    int   press_cnt1;

    debouncer_if #(.WIDTH(2)) dut_if ();

    debouncer #(
        .WIDTH          (2),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut_if.press_pulse[0] === 1'b1) press_cnt0++;
        if (dut_if.press_pulse[1] === 1'b1) press_cnt1++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1ns after the reset-release edge; the next edge is edge 1.
    task automatic test_reset();
        rst = 1'b1;
        dut_if.glitchy_signal = 2'b00;
        step(2);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00 || dut_if.press_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: deb=%b press=%b required 00/00",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
        rst = 1'b0;
        press_cnt0 = 0;
        press_cnt1 = 0;
    endtask

    task automatic test_press();
        test_reset();
        dut_if.glitchy_signal = 2'b01;
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00 || dut_if.press_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL first_cycle_after_reset: deb=%b press=%b required 00/00",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
        step(10);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00) begin
            n_fail++;
            $display("FAIL press_edge11: deb=%b required 00", dut_if.debounced_signal);
        end
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b01 || dut_if.press_pulse !== 2'b01) begin
            n_fail++;
            $display("FAIL press_edge12: deb=%b press=%b required 01/01",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b01 || dut_if.press_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL press_edge13: deb=%b press=%b required 01/00",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (dut_if.debounced_signal !== 2'b01 || dut_if.press_pulse !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_200: %0d bad cycles, required 0", bad);
        end
        n_checks++;
        if (press_cnt0 != 1 || press_cnt1 != 0) begin
            n_fail++;
            $display("FAIL hold_pulse_count: bit0=%0d bit1=%0d required 1/0",
                     press_cnt0, press_cnt1);
        end
    endtask

    task automatic test_release();
        dut_if.glitchy_signal = 2'b00;
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00 || dut_if.press_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL release_edge: deb=%b press=%b required 00/00",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
`ifdef DEBOUNCER_RELEASE_PULSE_EN
        n_checks++;
        if (dut_if.release_pulse !== 2'b01) begin
            n_fail++;
            $display("FAIL release_pulse_on: got %b required 01", dut_if.release_pulse);
        end
`endif
        step(1);
`ifdef DEBOUNCER_RELEASE_PULSE_EN
        n_checks++;
        if (dut_if.release_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL release_pulse_off: got %b required 00", dut_if.release_pulse);
        end
`endif
        n_checks++;
        if (press_cnt0 != 1) begin
            n_fail++;
            $display("FAIL release_no_press: count=%0d required 1", press_cnt0);
        end
    endtask

    // Ticks land on edges 4,8,...; the low cycle at edge 9 discards 2 ticks.
    task automatic test_glitch();
        test_reset();
        dut_if.glitchy_signal = 2'b01;
        step(8);
        dut_if.glitchy_signal = 2'b00;
        step(1);
        dut_if.glitchy_signal = 2'b01;
        step(10);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00 || press_cnt0 != 0) begin
            n_fail++;
            $display("FAIL glitch_edge19: deb=%b pulses=%0d required 00/0",
                     dut_if.debounced_signal, press_cnt0);
        end
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b01 || dut_if.press_pulse !== 2'b01) begin
            n_fail++;
            $display("FAIL glitch_edge20: deb=%b press=%b required 01/01",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
        step(3);
        n_checks++;
        if (press_cnt0 != 1) begin
            n_fail++;
            $display("FAIL glitch_pulse_count: count=%0d required 1", press_cnt0);
        end
    endtask

    task automatic test_simultaneous();
        test_reset();
        dut_if.glitchy_signal = 2'b11;
        step(11);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_edge11: deb=%b required 00", dut_if.debounced_signal);
        end
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b11 || dut_if.press_pulse !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_edge12: deb=%b press=%b required 11/11",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
    endtask

    task automatic test_reset_midpress();
        step(3);
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00 || dut_if.press_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_during: deb=%b press=%b required 00/00",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
`ifdef DEBOUNCER_RELEASE_PULSE_EN
        n_checks++;
        if (dut_if.release_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_release: got %b required 00", dut_if.release_pulse);
        end
`endif
        step(1);
        rst = 1'b0;
        press_cnt0 = 0;
        press_cnt1 = 0;
        step(11);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b00 || press_cnt0 != 0 || press_cnt1 != 0) begin
            n_fail++;
            $display("FAIL midreset_edge11: deb=%b pulses=%0d/%0d required 00/0/0",
                     dut_if.debounced_signal, press_cnt0, press_cnt1);
        end
        step(1);
        n_checks++;
        if (dut_if.debounced_signal !== 2'b11 || dut_if.press_pulse !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_edge12: deb=%b press=%b required 11/11",
                     dut_if.debounced_signal, dut_if.press_pulse);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        press_cnt0 = 0;
        press_cnt1 = 0;
        rst        = 1'b1;
        dut_if.glitchy_signal = 2'b00;
        step(1);
        test_press();
        test_hold();
        test_release();
        test_glitch();
        test_simultaneous();
        test_reset_midpress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_debouncer
`default_nettype wire
